// File: rtl/fetch_ifid.sv
// fetch_ifid: instruction-fetch stage with PC ownership, instruction-memory
// handshake and the IF/ID pipeline register feeding decode.
//
// Handshake: imem_req is the fetch valid and imem_rdy is the memory's ready.
// A fetch completes only in a cycle where both are high and the stage is free
// to consume the word (no stall, no redirect). imem_rdy describes only the
// current imem_addr in the current cycle. No request is ever outstanding, so
// the address may move on any edge.
//
// The FSM state is exposed directly on the halted output (HALTED <=> halted=1).
module fetch_ifid #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic [15:0] instr_out,
  output logic [15:0] PC_2_out,
  output logic        valid_out,
  output logic        halted,
  output logic        err
);

  typedef enum logic {
    S_FETCH  = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [15:0] pc, pc_next;
  logic [15:0] pc_plus2;
  logic [15:0] instr_next, pc2_next;
  logic        valid_next;
  logic        err_next;
  logic        accept;

  // Request and address come from state and PC only, so there is no
  // combinational path from any input to the memory interface.
  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;
  assign halted    = (state == S_HALTED);

  assign pc_plus2 = pc + 16'd2;
  assign accept   = (state == S_FETCH) && imem_rdy && !stall && !redirect;

  // Next-state, next-PC and next IF/ID contents; redirect beats stall beats
  // accept beats miss.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    instr_next = instr_out;
    pc2_next   = PC_2_out;
    valid_next = valid_out;
    err_next   = err | (imem_req & pc[0]) | (redirect & redirect_pc[0]);

    if (redirect) begin
      // Squash whatever is in IF/ID; also revives fetch after a wrong-path HALT.
      pc_next    = redirect_pc;
      instr_next = NOP_INSTR;
      pc2_next   = 16'h0000;
      valid_next = 1'b0;
      state_next = S_FETCH;
    end else if (stall) begin
      // Hold everything; any word on imem_data is simply not consumed.
    end else if (accept) begin
      instr_next = imem_data;
      pc2_next   = pc_plus2;
      valid_next = 1'b1;
      pc_next    = pc_plus2;
      if (imem_data[15:11] == HALT_OPC) begin
        state_next = S_HALTED;
      end
    end else begin
      // Miss in FETCH or idle in HALTED: feed decode a bubble so the previous
      // instruction is never executed twice.
      instr_next = NOP_INSTR;
      pc2_next   = 16'h0000;
      valid_next = 1'b0;
    end
  end

  // State, PC, IF/ID register and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      instr_out <= NOP_INSTR;
      PC_2_out  <= 16'h0000;
      valid_out <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      instr_out <= instr_next;
      PC_2_out  <= pc2_next;
      valid_out <= valid_next;
      err       <= err_next;
    end
  end

endmodule

// File: tb/tb_fetch_ifid.sv
// tb_fetch_ifid: directed scenarios with literal expectations followed by a
// randomized run, all checked every cycle against a behavioural fetch model.
module tb_fetch_ifid;

  localparam logic [15:0] NOP = 16'h0800;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        stall, redirect, imem_rdy;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr, imem_data;
  logic [15:0] instr_out, pc_2_out;
  logic        valid_out, halted, err;

  // Instruction memory image, word-indexed by address bits [8:1].
  logic [15:0] mem [0:255];
  assign imem_data = mem[imem_addr[8:1]];

  fetch_ifid dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdy    (imem_rdy),
    .imem_data   (imem_data),
    .instr_out   (instr_out),
    .PC_2_out    (pc_2_out),
    .valid_out   (valid_out),
    .halted      (halted),
    .err         (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the architectural view: where fetch is, whether it has stopped,
  // what decode should currently see, and the queue of fetched instructions.
  logic [15:0] m_pc, m_instr, m_pc2;
  logic        m_valid, m_halted, m_err, m_new;
  logic [31:0] exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= 16'h0000; m_instr <= NOP; m_pc2 <= 16'h0000;
      m_valid <= 1'b0; m_halted <= 1'b0; m_err <= 1'b0; m_new <= 1'b0;
      exp_q.delete();
    end else begin
      m_new <= 1'b0;
      if ((!m_halted && m_pc[0]) || (redirect && redirect_pc[0])) m_err <= 1'b1;
      if (redirect) begin
        m_pc <= redirect_pc; m_instr <= NOP; m_valid <= 1'b0; m_halted <= 1'b0;
      end else if (stall) begin
        // decode keeps seeing the same thing
      end else if (!m_halted && imem_rdy) begin
        m_instr <= imem_data;
        m_pc2   <= m_pc + 16'd2;
        m_pc    <= m_pc + 16'd2;
        m_valid <= 1'b1;
        m_new   <= 1'b1;
        exp_q.push_back({imem_data, m_pc + 16'd2});
        if (imem_data[15:11] == 5'b00000) m_halted <= 1'b1;
      end else begin
        m_instr <= NOP; m_valid <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      chk("imem_req", {15'd0, imem_req}, {15'd0, !m_halted});
      chk("imem_addr", imem_addr, m_pc);
      chk("instr_out", instr_out, m_instr);
      chk("valid_out", {15'd0, valid_out}, {15'd0, m_valid});
      chk("halted", {15'd0, halted}, {15'd0, m_halted});
      chk("err", {15'd0, err}, {15'd0, m_err});
      if (m_valid) chk("pc_2_out", pc_2_out, m_pc2);
      if (m_new) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard: got empty queue expected one entry at %0t", $time);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("sb_instr", instr_out, e[31:16]);
          chk("sb_pc2", pc_2_out, e[15:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a falling edge; drives inputs for the next rising edge.
  task automatic step(input logic rdy, input logic st, input logic rd, input logic [15:0] rpc);
    imem_rdy = rdy; stall = st; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    imem_rdy = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 16'(($urandom_range(1, 31) << 11) | $urandom_range(0, 2047));
    mem[0] = 16'hC001; mem[1] = 16'hC102; mem[2] = 16'hC204; mem[3] = 16'h0000;
    mem[7] = 16'hC0EE; mem[16] = 16'hC220; mem[255] = 16'hC3FE; mem[9] = 16'hC313;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    chk("rst_req", {15'd0, imem_req}, 16'd1);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_instr", instr_out, 16'h0800);
    chk("rst_valid", {15'd0, valid_out}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);

    // Asynchronous reset with PC = 0x0010 and a live instruction in IF/ID.
    step(1'b0, 1'b0, 1'b1, 16'h000E);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("pre_rst_addr", imem_addr, 16'h0010);
    chk("pre_rst_instr", instr_out, 16'hC0EE);
    imem_rdy = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_addr", imem_addr, 16'h0000);
    chk("arst_instr", instr_out, 16'h0800);
    chk("arst_valid", {15'd0, valid_out}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_req", {15'd0, imem_req}, 16'd1);
    chk("rel_addr", imem_addr, 16'h0000);

    // Streaming.
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("s1_instr", instr_out, 16'hC001);
    chk("s1_pc2", pc_2_out, 16'h0002);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("s2_instr", instr_out, 16'hC102);
    chk("s2_pc2", pc_2_out, 16'h0004);
    chk("s2_valid", {15'd0, valid_out}, 16'd1);

    // Misses then stall with data ready.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0000);
      chk("miss_valid", {15'd0, valid_out}, 16'd0);
      chk("miss_instr", instr_out, 16'h0800);
      chk("miss_addr", imem_addr, 16'h0004);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'h0000);
      chk("stall_valid", {15'd0, valid_out}, 16'd0);
      chk("stall_addr", imem_addr, 16'h0004);
    end
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("post_stall_instr", instr_out, 16'hC204);
    chk("post_stall_pc2", pc_2_out, 16'h0006);

    // HALT at address 6.
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("halt_instr", instr_out, 16'h0000);
    chk("halt_valid", {15'd0, valid_out}, 16'd1);
    chk("halt_pc2", pc_2_out, 16'h0008);
    chk("halt_flag", {15'd0, halted}, 16'd1);
    chk("halt_req", {15'd0, imem_req}, 16'd0);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("halt_bubble", {15'd0, valid_out}, 16'd0);
    chk("halt_addr", imem_addr, 16'h0008);

    // Redirect under stall, then to 0x20 and resume.
    step(1'b1, 1'b1, 1'b1, 16'h0040);
    chk("redir_addr", imem_addr, 16'h0040);
    chk("redir_instr", instr_out, 16'h0800);
    chk("redir_halted", {15'd0, halted}, 16'd0);
    step(1'b0, 1'b0, 1'b1, 16'h0020);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("resume_instr", instr_out, 16'hC220);
    chk("resume_pc2", pc_2_out, 16'h0022);

    // PC wrap and sticky misalignment error.
    step(1'b0, 1'b0, 1'b1, 16'hFFFE);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("wrap_instr", instr_out, 16'hC3FE);
    chk("wrap_pc2", pc_2_out, 16'h0000);
    chk("wrap_addr", imem_addr, 16'h0000);
    chk("wrap_err", {15'd0, err}, 16'd0);
    step(1'b0, 1'b0, 1'b1, 16'h0013);
    chk("err_set", {15'd0, err}, 16'd1);
    for (int i = 0; i < 10; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 16'h0000);
    chk("err_sticky", {15'd0, err}, 16'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("err_cleared", {15'd0, err}, 16'd0);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? 16'h0000 | 16'($urandom_range(0, 2047))
                                            : 16'(($urandom_range(1, 31) << 11) | $urandom_range(0, 2047));
    for (int n = 0; n < 3000; n++) begin
      logic        rd;
      logic [15:0] rpc;
      if (n % 400 == 399) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      rd  = ($urandom_range(0, 19) == 0);
      rpc = 16'($urandom_range(0, 65535)) & (($urandom_range(0, 15) == 0) ? 16'h01FF : 16'h01FE);
      if ($urandom_range(0, 40) == 0) rpc = 16'hFFFE;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, rd, rpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
